timer_share_sched: RTL and testbench

Scheduler that shares one Avalon-MM interval timer (16-bit register map) between N_REQ requesters. It arbitrates round-robin, programs the timer for a one-shot timeout, waits for the timer IRQ and clears it. It then returns a done pulse to the owning requester. It sits between the requesting state machines and the timer's s1 slave, and is the only master on that slave.

---
 rtl/timer_share_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_timer_share_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_share_sched.sv
// timer_share_sched: shares one Avalon-MM interval timer (16-bit register map) between
// N_REQ requesters. It grants round-robin, programs a one-shot timeout, waits for the
// timer IRQ, clears it and pulses done to the owner.
// Optional feature macro: TSS_WATCHDOG_EN adds a watchdog that aborts a WAIT lasting
// longer than period + WDOG_MARGIN cycles and reports it with err alongside done.
module timer_share_sched #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned WDOG_MARGIN = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_period,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic                  err,
    output logic                  busy,
    output logic [2:0]            tmr_address,
    output logic                  tmr_chipselect,
    output logic                  tmr_write_n,
    output logic [15:0]           tmr_writedata,
    input  logic                  tmr_irq
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    // Timer register map.
    localparam logic [2:0]  AddrStatus  = 3'd0;
    localparam logic [2:0]  AddrControl = 3'd1;
    localparam logic [2:0]  AddrPeriodL = 3'd2;
    localparam logic [2:0]  AddrPeriodH = 3'd3;
    // Control words: ITO|START one-shot, and STOP with ITO off.
    localparam logic [15:0] CtlStart    = 16'h0005;
    localparam logic [15:0] CtlStop     = 16'h0008;

    typedef enum logic [3:0] {
        StIdle,
        StWrPl,
        StWrPh,
        StGap,
        StWrCtl,
        StWait,
        StWrStop,
        StWrClr,
        StDone
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   last_owner_q;
    logic [15:0]        period_hi_q;
    logic               cancel_q;

    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic               pick_valid;
    logic [31:0]        pick_period;

`ifdef TSS_WATCHDOG_EN
    logic [15:0]        period_lo_q;
    logic [32:0]        wdog_q;
    logic               wdog_expired;
    logic               abort_q;
    logic               err_q;

    // Expiry is flagged on the last counted WAIT cycle so the abort leaves WAIT after
    // exactly period + WDOG_MARGIN cycles.
    assign wdog_expired = (wdog_q <= 33'd1);
    assign err          = err_q;

    // Watchdog counter: loaded while the START write is on the bus, counts down in WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q <= '0;
        end else if (state_q == StWrCtl) begin
            wdog_q <= 33'({period_hi_q, period_lo_q}) + 33'(WDOG_MARGIN);
        end else if (state_q == StWait && wdog_q != '0) begin
            wdog_q <= wdog_q - 33'd1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Round-robin pick: nearest requester after last_owner wins (descending loop, last hit
    // is the nearest).
    always_comb begin
        pick_valid  = 1'b0;
        pick_idx    = '0;
        cand        = '0;
        for (int s = int'(N_REQ); s >= 1; s--) begin
            cand = IDX_W'((int'(last_owner_q) + s) % int'(N_REQ));
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_period = req_period[{pick_idx, 5'b00000} +: 32];
    end

    // Main FSM with all bus and handshake outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            owner_q        <= '0;
            last_owner_q   <= IDX_W'(N_REQ - 1);
            period_hi_q    <= '0;
            cancel_q       <= 1'b0;
            grant          <= '0;
            done           <= '0;
            busy           <= 1'b0;
            tmr_address    <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= '0;
`ifdef TSS_WATCHDOG_EN
            period_lo_q    <= '0;
            abort_q        <= 1'b0;
            err_q          <= 1'b0;
`endif
        end else begin
            done <= '0;
`ifdef TSS_WATCHDOG_EN
            err_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        owner_q        <= pick_idx;
                        period_hi_q    <= pick_period[31:16];
                        cancel_q       <= 1'b0;
                        grant          <= N_REQ'(1) << pick_idx;
                        busy           <= 1'b1;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= AddrPeriodL;
                        tmr_writedata  <= pick_period[15:0];
`ifdef TSS_WATCHDOG_EN
                        period_lo_q    <= pick_period[15:0];
                        abort_q        <= 1'b0;
`endif
                        state_q        <= StWrPl;
                    end
                end
                StWrPl: begin
                    tmr_address   <= AddrPeriodH;
                    tmr_writedata <= period_hi_q;
                    state_q       <= StWrPh;
                end
                StWrPh: begin
                    // Idle cycle so the timer's reload from the period write settles.
                    tmr_chipselect <= 1'b0;
                    tmr_write_n    <= 1'b1;
                    state_q        <= StGap;
                end
                StGap: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= AddrControl;
                    tmr_writedata  <= CtlStart;
                    state_q        <= StWrCtl;
                end
                StWrCtl: begin
                    tmr_chipselect <= 1'b0;
                    tmr_write_n    <= 1'b1;
                    state_q        <= StWait;
                end
                StWait: begin
                    if (tmr_irq) begin
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= AddrStatus;
                        tmr_writedata  <= 16'h0000;
                        state_q        <= StWrClr;
                    end else if (!req[owner_q]) begin
                        cancel_q       <= 1'b1;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= AddrControl;
                        tmr_writedata  <= CtlStop;
                        state_q        <= StWrStop;
                    end
`ifdef TSS_WATCHDOG_EN
                    else if (wdog_expired) begin
                        abort_q        <= 1'b1;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= AddrControl;
                        tmr_writedata  <= CtlStop;
                        state_q        <= StWrStop;
                    end
`endif
                end
                StWrStop: begin
                    tmr_address   <= AddrStatus;
                    tmr_writedata <= 16'h0000;
                    state_q       <= StWrClr;
                end
                StWrClr: begin
                    tmr_chipselect <= 1'b0;
                    tmr_write_n    <= 1'b1;
                    if (cancel_q) begin
                        // Cancelled owner gets no pulse and does not move the RR pointer.
                        grant   <= '0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        done    <= grant;
`ifdef TSS_WATCHDOG_EN
                        err_q   <= abort_q;
`endif
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    grant        <= '0;
                    busy         <= 1'b0;
                    last_owner_q <= owner_q;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_share_sched.sv
// tb_timer_share_sched: self-checking bench for timer_share_sched. Directed scenarios plus
// randomized request mixes; expected grants come from a round-robin model over the request
// mask, expected bus traffic and handshake timing from the documented cycle sequence.
`timescale 1ns/1ps
module tb_timer_share_sched;

    localparam int N      = 4;
    localparam int MARGIN = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [32*N-1:0]   req_period;
    logic [N-1:0]      grant;
    logic [N-1:0]      done;
    logic              err;
    logic              busy;
    logic [2:0]        tmr_address;
    logic              tmr_chipselect;
    logic              tmr_write_n;
    logic [15:0]       tmr_writedata;
    logic              tmr_irq;

    int errors = 0;
    int checks = 0;
    int last_m;
    logic [31:0] per_m [N];

    timer_share_sched #(
        .N_REQ       (N),
        .WDOG_MARGIN (MARGIN)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_period     (req_period),
        .grant          (grant),
        .done           (done),
        .err            (err),
        .busy           (busy),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first set bit after 'last', wrapping.
    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int s = 1; s <= N; s++) begin
            if (m[(last + s) % N]) return (last + s) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] p);
        per_m[i]                = p;
        req_period[32*i +: 32]  = p;
        req[i]                  = 1'b1;
    endtask

    // One transaction for owner 'exp', starting in IDLE with req sampled at the next edge.
    // mode 0: irq, 1: cancel, 2: irq and cancel in the same cycle, 3: watchdog abort.
    task automatic run_txn(input int exp, input int wdelay, input int mode);
        logic [31:0]  p;
        logic [N-1:0] oh;
        int           cnt;
        p  = per_m[exp];
        oh = N'(1) << exp;
        step;
        checks++;
        if ({grant, busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !==
            {oh, 1'b1, 1'b1, 1'b0, 3'd2, p[15:0]})
            begin errors++; $display("FAIL wr_pl: grant=%b cs=%b wn=%b a=%0d d=%h want grant=%b a=2 d=%h",
                grant, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, oh, p[15:0]); end
        step;
        checks++;
        if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd3, p[31:16]})
            begin errors++; $display("FAIL wr_ph: cs=%b wn=%b a=%0d d=%h want a=3 d=%h",
                tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, p[31:16]); end
        step;
        checks++;
        if ({tmr_chipselect, tmr_write_n, busy} !== 3'b011)
            begin errors++; $display("FAIL gap: cs=%b wn=%b busy=%b want 0 1 1",
                tmr_chipselect, tmr_write_n, busy); end
        step;
        checks++;
        if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0005})
            begin errors++; $display("FAIL wr_ctl: cs=%b wn=%b a=%0d d=%h want a=1 d=0005",
                tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata); end
        step;
        if (mode != 3) begin
            repeat (wdelay) begin
                checks++;
                if ({tmr_chipselect, tmr_write_n, busy, done, grant} !== {1'b0, 1'b1, 1'b1, {N{1'b0}}, oh})
                    begin errors++; $display("FAIL wait: cs=%b wn=%b busy=%b done=%b grant=%b",
                        tmr_chipselect, tmr_write_n, busy, done, grant); end
                step;
            end
        end
        if (mode == 0 || mode == 2) begin
            tmr_irq = 1'b1;
            if (mode == 2) req[exp] = 1'b0;
            step;
            tmr_irq = 1'b0;
            checks++;
            if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, done} !==
                {1'b1, 1'b0, 3'd0, 16'h0000, {N{1'b0}}})
                begin errors++; $display("FAIL clr_after_irq: cs=%b wn=%b a=%0d d=%h done=%b want a=0 d=0000",
                    tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, done); end
            step;
            checks++;
            if ({done, err, grant, tmr_chipselect} !== {oh, 1'b0, oh, 1'b0})
                begin errors++; $display("FAIL done: done=%b err=%b grant=%b cs=%b want done=%b err=0",
                    done, err, grant, tmr_chipselect, oh); end
            req[exp] = 1'b0;
            step;
            last_m = exp;
        end else if (mode == 1) begin
            req[exp] = 1'b0;
            step;
            checks++;
            if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, done} !==
                {1'b1, 1'b0, 3'd1, 16'h0008, {N{1'b0}}})
                begin errors++; $display("FAIL stop: cs=%b a=%0d d=%h done=%b want a=1 d=0008",
                    tmr_chipselect, tmr_address, tmr_writedata, done); end
            step;
            checks++;
            if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, done} !==
                {1'b1, 1'b0, 3'd0, 16'h0000, {N{1'b0}}})
                begin errors++; $display("FAIL clr_after_stop: cs=%b a=%0d d=%h done=%b want a=0 d=0000",
                    tmr_chipselect, tmr_address, tmr_writedata, done); end
            step;
        end else begin
            cnt = 0;
            while (tmr_chipselect !== 1'b1 && cnt < 300) begin
                cnt++;
                step;
            end
            checks++;
            if (cnt != int'(p) + MARGIN)
                begin errors++; $display("FAIL wdog_cycles: got %0d WAIT cycles want %0d",
                    cnt, int'(p) + MARGIN); end
            checks++;
            if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0008})
                begin errors++; $display("FAIL wdog_stop: cs=%b a=%0d d=%h want a=1 d=0008",
                    tmr_chipselect, tmr_address, tmr_writedata); end
            step;
            checks++;
            if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd0, 16'h0000})
                begin errors++; $display("FAIL wdog_clr: cs=%b a=%0d d=%h want a=0 d=0000",
                    tmr_chipselect, tmr_address, tmr_writedata); end
            step;
            checks++;
            if ({done, err} !== {oh, 1'b1})
                begin errors++; $display("FAIL wdog_done: done=%b err=%b want done=%b err=1",
                    done, err, oh); end
            req[exp] = 1'b0;
            step;
            last_m = exp;
        end
        // Back in IDLE: nothing granted yet even if other requests are pending.
        checks++;
        if ({busy, done, err, grant, tmr_chipselect, tmr_write_n} !== {1'b0, {N{1'b0}}, 1'b0, {N{1'b0}}, 1'b0, 1'b1})
            begin errors++; $display("FAIL idle: busy=%b done=%b err=%b grant=%b cs=%b wn=%b want all idle",
                busy, done, err, grant, tmr_chipselect, tmr_write_n); end
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        req        = '0;
        req_period = '0;
        tmr_irq    = 1'b0;
        step;
        step;
        checks++;
        if ({grant, done, err, busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !==
            {{N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000})
            begin errors++; $display("FAIL reset: grant=%b done=%b err=%b busy=%b cs=%b wn=%b a=%0d d=%h",
                grant, done, err, busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata); end
        reset_n = 1'b1;
        last_m  = N - 1;
        step;
    endtask

    task automatic test_basic;
        set_req(1, 32'd10);
        run_txn(1, 3, 0);
    endtask

    task automatic test_round_robin;
        set_req(0, 32'h0001_2345);
        run_txn(0, 1, 0);
        set_req(0, 32'd7);
        set_req(2, 32'hABCD_0003);
        run_txn(2, 2, 0);
        run_txn(0, 0, 0);
        set_req(2, 32'd1);
        run_txn(2, 1, 0);
        set_req(0, 32'd9);
        set_req(3, 32'h8000_0000);
        run_txn(3, 2, 0);
        run_txn(0, 1, 0);
    endtask

    task automatic test_cancel;
        set_req(2, 32'h0000_FFFF);
        run_txn(2, 4, 1);
    endtask

    task automatic test_irq_and_cancel;
        set_req(3, 32'd0);
        run_txn(3, 2, 2);
    endtask

    task automatic test_watchdog;
`ifdef TSS_WATCHDOG_EN
        set_req(1, 32'd5);
        run_txn(1, 0, 3);
`else
        // Without the watchdog a long WAIT is never aborted.
        set_req(1, 32'd5);
        run_txn(1, 30, 0);
`endif
    endtask

    task automatic test_reset_in_wait;
        set_req(2, 32'd100);
        repeat (5) step;
        reset_n = 1'b0;
        req     = '0;
        #2;
        checks++;
        if ({grant, done, err, busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !==
            {{N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000})
            begin errors++; $display("FAIL reset_in_wait: grant=%b busy=%b cs=%b wn=%b a=%0d d=%h",
                grant, busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata); end
        step;
        reset_n = 1'b1;
        last_m  = N - 1;
        step;
        set_req(3, 32'd4);
        set_req(0, 32'd6);
        run_txn(0, 1, 0);
        run_txn(3, 0, 0);
    endtask

    task automatic test_random;
        logic [N-1:0] m;
        int           exp;
        repeat (40) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (m[i]) set_req(i, $urandom);
            end
            while (req != '0) begin
                exp = rr_pick(req, last_m);
                run_txn(exp, $urandom_range(0, 12), $urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_round_robin;
        test_cancel;
        test_irq_and_cancel;
        test_watchdog;
        test_reset_in_wait;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
